poly_lift_phi1_mul: RTL and testbench
=====================================

# poly_lift_phi1_mul

Streaming multiply-by-(x−1) stage of the NTRU-HRSS polynomial lift. It consumes the ternary coefficients of v = m/Φ1 (mod 3) from the inverse-Φ1 stage at two coefficients per beat. It emits the lifted polynomial (x−1)·v mod (xᴺ−1) as pairs of LOGQ-bit two's-complement coefficients, each tagged with a pair address for the downstream coefficient RAM.

## Interface
- N, 701, polynomial length (odd)
- LOGQ, 13, output coefficient width (q = 2^LOGQ)
- PAIRS, (N+1)/2, beats per polynomial (351)
- AW, $clog2(PAIRS), pair-address width (9)

- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  one-cycle pulse that begins a polynomial; ignored unless IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_coef  in  4  [1:0] = v₂ₖ, [3:2] = v₂ₖ₊₁; ternary encoding 00=0, 01=+1, 11=−1, 10 treated as 0
- out_valid  out  1  output pair valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_addr  out  AW  pair index k; lane0 = c₂ₖ, lane1 = c₂ₖ₊₁
- out_coef0  out  LOGQ  c₂ₖ, two's complement mod q
- out_coef1  out  LOGQ  c₂ₖ₊₁; forced 0 when 2k+1 = N
- out_last  out  1  marks the final pair of the polynomial
- done  out  1  one-cycle pulse after the final pair handshake

## Operation
- Math: cᵢ = vᵢ₋₁ − vᵢ, with v₋₁ = v_{N−1}. The result is in {−2..2}, sign-extended to LOGQ bits (−1 → 0x1FFF, −2 → 0x1FFE, +2 → 0x0002).
- FSM states: IDLE, RUN, WRAP, FLUSH.
  - IDLE: in_ready=0. start → RUN with beat counter k=0.
  - RUN: in_ready = !out_valid | out_ready (single output register, full throughput).
    - Beat k=0: store v0 and v1 in the wrap registers and set prev=v1. No output is produced.
    - Beat k≥1: load the output register with addr=k, c₂ₖ = prev − v₂ₖ, c₂ₖ₊₁ = v₂ₖ − v₂ₖ₊₁. Then set prev = v₂ₖ₊₁.
    - Beat k=PAIRS−1: in_coef[3:2] is ignored, coef1=0, and prev=v₂ₖ (= v_{N−1}). → WRAP.
  - WRAP: in_ready=0. When the output register is free or draining, load addr=0, c0 = prev − v0, c1 = v0 − v1, out_last=1. → FLUSH.
  - FLUSH: on the out_last handshake, pulse done and → IDLE.
- Output order: addr 1, 2, …, PAIRS−1, then 0.
- The output register holds all fields stable while out_valid & !out_ready.
- start outside IDLE has no effect. in_valid outside RUN is ignored.

## Timing
- Reset values: in_ready=0, out_valid=0, out_addr=0, out_coef0=0, out_coef1=0, out_last=0, done=0. State=IDLE, counters and registers cleared.
- start seen at edge t → in_ready=1 from cycle t+1 if no output is pending.
- Latency: an input handshake at edge t gives out_valid at t+1, except beat 0, which produces no output.
- The addr 0 pair appears no earlier than 1 cycle after the PAIRS−1 input handshake.
- done is asserted in the cycle after the out_last handshake.
- Best case per polynomial: PAIRS input cycles + 1 wrap cycle + 1 done cycle.
- Simultaneous out handshake and new input in the same cycle: the register reloads and out_valid stays 1.
- rst mid-polynomial: the partial polynomial is discarded, no done pulse, and the block returns to the reset values on the next edge.
- Beat counter wrap: k saturates at PAIRS−1. It never wraps inside RUN.

## Structure
- Package poly_lift_pkg holds:
  - N, LOGQ, PAIRS, AW
  - ternary encoding constants (TER_ZERO, TER_POS, TER_NEG)
  - FSM state enum
- Sub-module ter_sub_q: combinational (x, y ternary) → LOGQ-bit two's-complement x−y. It is instantiated twice, shared between the RUN and WRAP datapaths through an operand mux.

## Test plan
- All-zero v → 351 pairs, all coefs 0. Order is addr 1..350 then 0. out_last only on addr 0. done once.
- All +1 v → every output coefficient 0. addr 350 has coef1=0.
- v0=+1, rest 0 → addr 0: c0=0x1FFF, c1=0x0001. All others 0.
- v0=+1, v700=−1, rest 0 → c0=0x1FFE, c1=0x0001, addr 350 coef0 = v699−v700 = 0x0001.
- Random v with random in_valid gaps and out_ready backpressure → matches the reference model. Output fields stay stable while stalled. No beats are lost or duplicated.
- rst asserted after 100 input beats → outputs at reset values next cycle. A fresh start then completes correctly. Also: code 10 on input behaves identically to 00.

Source files
------------

// File: rtl/poly_lift_pkg.sv
// Shared parameters, ternary coefficient encoding and FSM states for the
// multiply-by-(x-1) lift stage.
package poly_lift_pkg;

   localparam int N     = 701;
   localparam int LOGQ  = 13;
   localparam int PAIRS = (N + 1) / 2;
   localparam int AW    = $clog2(PAIRS);

   localparam logic [1:0] TER_ZERO = 2'b00;
   localparam logic [1:0] TER_POS  = 2'b01;
   localparam logic [1:0] TER_NEG  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_WRAP  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // Code 10 is unused by the producer and decodes as zero.
   function automatic logic signed [2:0] ter_val(input logic [1:0] c);
      logic signed [2:0] r;
      r = 3'sd0;
      if (c == TER_POS) r = 3'sd1;
      else if (c == TER_NEG) r = -3'sd1;
      return r;
   endfunction

endpackage

// File: rtl/ter_sub_q.sv
// Combinational ternary difference x - y, sign-extended to a LOGQ-bit
// two's-complement coefficient (range -2..2).
module ter_sub_q
   import poly_lift_pkg::*;
(
   input  logic [1:0]      x,
   input  logic [1:0]      y,
   output logic [LOGQ-1:0] d
);

   logic signed [2:0] x_val;
   logic signed [2:0] y_val;
   logic signed [2:0] diff;

   assign x_val = ter_val(x);
   assign y_val = ter_val(y);
   assign diff  = x_val - y_val;
   assign d     = {{(LOGQ-3){diff[2]}}, diff};

endmodule

// File: rtl/poly_lift_phi1_mul.sv
// Streaming (x-1)*v mod (x^N-1) stage: two ternary coefficients in per beat,
// two LOGQ-bit coefficients plus pair address out, wrap pair emitted last.
module poly_lift_phi1_mul
   import poly_lift_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_coef,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [AW-1:0]   out_addr,
   output logic [LOGQ-1:0] out_coef0,
   output logic [LOGQ-1:0] out_coef1,
   output logic            out_last,
   output logic            done
);

   localparam logic [AW-1:0] K_LAST = AW'(PAIRS - 1);

   // Handshake: a beat moves on a port in any cycle where valid & ready are
   // both high at the rising edge; the output register reloads on the same
   // edge it drains, so out_valid can stay high across back-to-back pairs.

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   k;
   logic [1:0]      prev;
   logic [1:0]      wrap0;
   logic [1:0]      wrap1;
   logic            out_free;
   logic            accept;
   logic            wrap_load;
   logic            k_first;
   logic            k_last;
   logic [1:0]      op0_x;
   logic [1:0]      op0_y;
   logic [1:0]      op1_x;
   logic [1:0]      op1_y;
   logic [LOGQ-1:0] diff0;
   logic [LOGQ-1:0] diff1;

   assign out_free = !out_valid || out_ready;
   assign k_first  = (k == '0);
   assign k_last   = (k == K_LAST);

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      wrap_load = 1'b0;
      op0_x     = prev;
      op0_y     = in_coef[1:0];
      op1_x     = in_coef[1:0];
      op1_y     = in_coef[3:2];
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            in_ready = out_free;
            accept   = in_valid && out_free;
            if (accept && k_last) state_nx = ST_WRAP;
         end
         ST_WRAP: begin
            // Closing pair: c0 = v[N-1] - v0, c1 = v0 - v1.
            op0_y = wrap0;
            op1_x = wrap0;
            op1_y = wrap1;
            if (out_free) begin
               wrap_load = 1'b1;
               state_nx  = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (out_valid && out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   ter_sub_q u_sub0 (.x(op0_x), .y(op0_y), .d(diff0));
   ter_sub_q u_sub1 (.x(op1_x), .y(op1_y), .d(diff1));

   always_ff @(posedge clk) begin
      if (rst) begin
         k         <= '0;
         prev      <= TER_ZERO;
         wrap0     <= TER_ZERO;
         wrap1     <= TER_ZERO;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_coef0 <= '0;
         out_coef1 <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= (state == ST_FLUSH) && out_valid && out_ready;

         if (state == ST_IDLE && start) k <= '0;

         if (accept) begin
            if (!k_last) k <= k + 1'b1;
            if (k_first) begin
               wrap0 <= in_coef[1:0];
               wrap1 <= in_coef[3:2];
               prev  <= in_coef[3:2];
            end else if (k_last) begin
               prev <= in_coef[1:0];
            end else begin
               prev <= in_coef[3:2];
            end
         end

         if (accept && !k_first) begin
            out_valid <= 1'b1;
            out_addr  <= k;
            out_coef0 <= diff0;
            // Lane 1 of the last pair would be index N, which does not exist.
            out_coef1 <= k_last ? '0 : diff1;
            out_last  <= 1'b0;
         end else if (wrap_load) begin
            out_valid <= 1'b1;
            out_addr  <= '0;
            out_coef0 <= diff0;
            out_coef1 <= diff1;
            out_last  <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_poly_lift_phi1_mul.sv
// Bench for poly_lift_phi1_mul: table of polynomial cases with probe values,
// scoreboard queue fed from a direct c[i] = v[i-1] - v[i] model.
module tb_poly_lift_phi1_mul;
   import poly_lift_pkg::*;

   localparam int EW = 1 + AW + 2 * LOGQ;

   logic            clk;
   logic            rst;
   logic            start;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_coef;
   logic            out_valid;
   logic            out_ready;
   logic [AW-1:0]   out_addr;
   logic [LOGQ-1:0] out_coef0;
   logic [LOGQ-1:0] out_coef1;
   logic            out_last;
   logic            done;

   poly_lift_phi1_mul dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_coef(in_coef), .out_valid(out_valid),
      .out_ready(out_ready), .out_addr(out_addr), .out_coef0(out_coef0),
      .out_coef1(out_coef1), .out_last(out_last), .done(done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   bit bp_en = 1'b0;

   logic [EW-1:0]   exp_q[$];
   logic [1:0]      v[N];
   logic [LOGQ-1:0] got0[PAIRS];
   logic [LOGQ-1:0] got1[PAIRS];

   typedef struct {
      int              pat;
      bit              gaps;
      bit              bp;
      bit              probe;
      int              paddr;
      logic [LOGQ-1:0] p0;
      logic [LOGQ-1:0] p1;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int tv(input logic [1:0] c);
      if (c == 2'b01) return 1;
      if (c == 2'b11) return -1;
      return 0;
   endfunction

   function automatic logic [LOGQ-1:0] mc(input int i);
      int d;
      d = tv(v[(i + N - 1) % N]) - tv(v[i]);
      return LOGQ'(d);
   endfunction

   function automatic logic [1:0] rnd_code(input bit allow_10);
      int r;
      r = allow_10 ? $urandom_range(0, 3) : $urandom_range(0, 2);
      case (r)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic build_v(input int pat);
      for (int i = 0; i < N; i++) begin
         case (pat)
            1: v[i] = 2'b01;
            2: v[i] = (i == 0) ? 2'b01 : 2'b00;
            3: v[i] = (i == 0) ? 2'b01 : ((i == N - 1) ? 2'b11 : 2'b00);
            4: v[i] = rnd_code(1'b0);
            5: v[i] = rnd_code(1'b1);
            6: v[i] = 2'b10;
            default: v[i] = 2'b00;
         endcase
      end
   endtask

   // ---------------- output backpressure ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic          stall_q;
      logic [EW-1:0] stall_rec;
      logic [EW-1:0] cur;
      logic [EW-1:0] exp;
      stall_q = 1'b0;
      stall_rec = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_q = 1'b0;
         end else begin
            cur = {out_last, out_addr, out_coef0, out_coef1};
            if (stall_q) check("stall_hold", {out_valid, cur}, {1'b1, stall_rec});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", {1'b1, cur}, '0);
               end else begin
                  exp = exp_q.pop_front();
                  check("out_pair", cur, exp);
               end
               got0[out_addr] = out_coef0;
               got1[out_addr] = out_coef1;
               stall_q = 1'b0;
            end else if (out_valid) begin
               stall_q = 1'b1;
               stall_rec = cur;
            end else begin
               stall_q = 1'b0;
            end
            if (done) done_cnt++;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_poly(input int pat, input bit gaps, input bit bp, input int abort_at);
      int beat;
      int guard;
      int lim;
      bit hs;
      build_v(pat);
      bp_en = bp;
      for (int a = 0; a < PAIRS; a++) begin
         got0[a] = 'x;
         got1[a] = 'x;
      end
      for (int kk = 1; kk < PAIRS; kk++)
         exp_q.push_back({1'b0, AW'(kk), mc(2 * kk), (2 * kk + 1 < N) ? mc(2 * kk + 1) : LOGQ'(0)});
      exp_q.push_back({1'b1, AW'(0), mc(0), mc(1)});
      done_cnt = 0;

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_ready", in_ready, 1'b1);

      lim = (abort_at >= 0) ? abort_at : PAIRS;
      beat = 0;
      guard = 0;
      while (beat < lim && guard < 6000) begin
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (beat == PAIRS - 1) in_coef = {2'b11, v[2 * beat]};
         else                   in_coef = {v[2 * beat + 1], v[2 * beat]};
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         guard++;
         if (hs) begin
            beat++;
            if (!gaps && beat == 1) check("beat0_no_out", out_valid, 1'b0);
            if (!gaps && beat == 2) check("beat1_latency", out_valid, 1'b1);
         end
      end
      in_valid = 1'b0;
      check("beats_taken", beat, lim);
      if (abort_at < 0) begin
         guard = 0;
         while ((exp_q.size() != 0 || done_cnt == 0) && guard < 4000) begin
            @(posedge clk);
            guard++;
         end
         repeat (3) @(posedge clk);
         #1;
         check("queue_drained", exp_q.size(), 0);
         check("done_count", done_cnt, 1);
      end
   endtask

   // ---------------- main ----------------
   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_coef = 4'h0;

      tbl[0] = '{pat: 0, gaps: 0, bp: 0, probe: 1, paddr: 0,   p0: 13'h0000, p1: 13'h0000};
      tbl[1] = '{pat: 1, gaps: 0, bp: 0, probe: 1, paddr: 350, p0: 13'h0000, p1: 13'h0000};
      tbl[2] = '{pat: 2, gaps: 0, bp: 0, probe: 1, paddr: 0,   p0: 13'h1FFF, p1: 13'h0001};
      tbl[3] = '{pat: 3, gaps: 0, bp: 0, probe: 1, paddr: 0,   p0: 13'h1FFE, p1: 13'h0001};
      tbl[4] = '{pat: 3, gaps: 1, bp: 1, probe: 1, paddr: 350, p0: 13'h0001, p1: 13'h0000};
      tbl[5] = '{pat: 4, gaps: 1, bp: 1, probe: 0, paddr: 0,   p0: 13'h0000, p1: 13'h0000};
      tbl[6] = '{pat: 5, gaps: 1, bp: 1, probe: 0, paddr: 0,   p0: 13'h0000, p1: 13'h0000};
      tbl[7] = '{pat: 6, gaps: 0, bp: 1, probe: 1, paddr: 0,   p0: 13'h0000, p1: 13'h0000};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_vals", {in_ready, out_valid, out_addr, out_coef0, out_coef1, out_last, done}, '0);

      for (int i = 0; i < 8; i++) begin
         run_poly(tbl[i].pat, tbl[i].gaps, tbl[i].bp, -1);
         if (tbl[i].probe) begin
            check("probe_c0", got0[tbl[i].paddr], tbl[i].p0);
            check("probe_c1", got1[tbl[i].paddr], tbl[i].p1);
         end
      end

      // Mid-polynomial reset, then a clean polynomial.
      run_poly(4, 0, 0, 100);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_mid_vals", {in_ready, out_valid, out_addr, out_coef0, out_coef1, out_last, done}, '0);
      exp_q.delete();
      done_cnt = 0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_no_done", done_cnt, 0);
      run_poly(5, 1, 1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
